// File: rtl/ct_spsram_512x7_init_ctrl.sv
// rtl/ct_spsram_512x7_init_ctrl.sv - 512x7 single-port SRAM front end with init sweep
// Sweeps the array to INIT_VAL after reset or on clr_req, then serves masked writes and reads.
module ct_spsram_512x7_init_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 9,
    parameter int unsigned           DATA_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr_req,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    busy;
    logic                    accept;
    logic                    clr_take;
    logic                    last_addr;

    // A held response blocks new accesses so the macro's Q output stays put.
    assign busy      = rsp_vld & ~rsp_rdy;
    assign req_rdy   = ~RST & (state == S_IDLE) & ~busy & ~clr_req;
    assign accept    = req_vld & req_rdy;
    assign clr_take  = (state == S_IDLE) & clr_req & ~busy;
    assign last_addr = &cnt;
    assign rsp_data  = sram_q;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (!RST) begin
            if (state == S_INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt;
                sram_d    = INIT_VAL;
            end else if (accept) begin
                sram_cen = 1'b0;
                if (req_wr) begin
                    sram_gwen = 1'b0;
                    sram_wen  = ~req_wmask;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_INIT;
            cnt       <= '0;
            rsp_vld   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (last_addr) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clr_take) begin
                        // Not busy here, so any pending response is being consumed this cycle.
                        state     <= S_INIT;
                        cnt       <= '0;
                        init_done <= 1'b0;
                        rsp_vld   <= 1'b0;
                    end else if (accept && !req_wr) begin
                        rsp_vld <= 1'b1;
                    end else if (rsp_vld && rsp_rdy) begin
                        rsp_vld <= 1'b0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_spsram_512x7_init_ctrl.sv
// tb/tb_ct_spsram_512x7_init_ctrl.sv - self-checking bench for ct_spsram_512x7_init_ctrl
module tb_ct_spsram_512x7_init_ctrl;
    localparam int AW    = 9;
    localparam int DW    = 7;
    localparam int DEPTH = 512;
    localparam logic [DW-1:0] INIT_VAL = 7'h2A;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          clr_req = 1'b0;
    logic          init_done;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;

    logic [DW-1:0] macro_mem [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            tests = 0;
    int            fails = 0;
    bit            rand_rdy = 1'b0;

    always #5 CLK = ~CLK;

    ct_spsram_512x7_init_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_VAL  (INIT_VAL)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .clr_req  (clr_req),
        .init_done(init_done),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_data (rsp_data),
        .sram_a   (sram_a),
        .sram_cen (sram_cen),
        .sram_gwen(sram_gwen),
        .sram_wen (sram_wen),
        .sram_d   (sram_d),
        .sram_q   (sram_q)
    );

    // Macro stand-in: bit-masked write, registered read, Q held when idle or writing.
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= macro_mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp();
        logic [DW-1:0] e;
        if (rsp_vld === 1'b1 && rsp_rdy) begin
            if (exp_q.size() == 0) chk("rsp_spurious", 32'(rsp_vld), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e));
            end
        end
    endtask

    task automatic tick();
        #1;
        chk_rsp();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_shadow_init();
        for (int i = 0; i < DEPTH; i++) shadow[i] = INIT_VAL;
    endtask

    task automatic sweep(input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            #1;
            chk("sweep", {5'd0, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req_rdy, init_done},
                {5'd0, 1'b0, 1'b0, 7'h00, 9'(k), INIT_VAL, 1'b0, 1'b0});
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_cen", 32'(sram_cen), 32'd1);
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        @(posedge CLK);
        #1;
        chk("rst_state", {30'd0, rsp_vld, init_done}, 32'd0);
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] wmask);
        int            n;
        logic [DW-1:0] wen_exp;
        n = 0;
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        #1;
        while (req_rdy !== 1'b1 && n < 64) begin
            chk_rsp();
            @(posedge CLK);
            #1;
            if (rand_rdy) rsp_rdy = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        if (req_rdy !== 1'b1) begin
            chk("req_timeout", 32'(req_rdy), 32'd1);
            req_vld = 1'b0;
            return;
        end
        wen_exp = wr ? ~wmask : {DW{1'b1}};
        chk("acc_ctl", {15'd0, sram_cen, sram_gwen, sram_wen, sram_a},
            {15'd0, 1'b0, ~wr, wen_exp, addr});
        if (wr) begin
            chk("acc_d", 32'(sram_d), 32'(wdata));
            shadow[addr] = (shadow[addr] & ~wmask) | (wdata & wmask);
        end else begin
            exp_q.push_back(shadow[addr]);
        end
        chk_rsp();
        @(posedge CLK);
        #1;
        req_vld = 1'b0;
        if (!wr) chk("rd_lat", 32'(rsp_vld), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) macro_mem[i] = DW'($urandom);
        fill_shadow_init();

        // T1: power-on sweep
        @(posedge CLK);
        #1;
        do_reset();
        sweep(0, DEPTH);
        #1;
        chk("init_done_rise", 32'(init_done), 32'd1);
        chk("rdy_after_init", 32'(req_rdy), 32'd1);

        // T2: full write, read back
        issue(1'b1, 9'h1A5, 7'h55, 7'h7F);
        issue(1'b0, 9'h1A5, 7'h00, 7'h00);
        chk("t2_data", 32'(rsp_data), 32'h55);
        tick();

        // T3: masked write keeps unmasked bits, then zero-mask write is a no-op
        issue(1'b1, 9'h010, 7'h7F, 7'h7F);
        issue(1'b1, 9'h010, 7'h00, 7'h0F);
        issue(1'b0, 9'h010, 7'h00, 7'h00);
        chk("t3_data", 32'(rsp_data), 32'h70);
        issue(1'b1, 9'h010, 7'h0F, 7'h00);
        issue(1'b0, 9'h010, 7'h00, 7'h00);
        chk("t3_nomask", 32'(rsp_data), 32'h70);
        tick();

        // T4: stalled response, then back-to-back reads
        issue(1'b1, 9'h000, 7'h11, 7'h7F);
        issue(1'b1, 9'h001, 7'h22, 7'h7F);
        issue(1'b1, 9'h002, 7'h33, 7'h7F);
        rsp_rdy = 1'b0;
        issue(1'b0, 9'h000, 7'h00, 7'h00);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'h001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_hold", {20'd0, rsp_vld, rsp_data, req_rdy, sram_cen, 2'b00},
                {20'd0, 1'b1, 7'h11, 1'b0, 1'b1, 2'b00});
            @(posedge CLK);
            #1;
        end
        rsp_rdy = 1'b1;
        issue(1'b0, 9'h001, 7'h00, 7'h00);
        issue(1'b0, 9'h002, 7'h00, 7'h00);
        chk("t4_last", 32'(rsp_data), 32'h33);
        tick();
        tick();
        chk("t4_drain", 32'(exp_q.size()), 32'd0);

        // Random traffic with random backpressure on a small address window
        rand_rdy = 1'b1;
        for (int op = 0; op < 300; op++) begin
            rsp_rdy = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 1'b0;
        rsp_rdy = 1'b1;
        tick();
        tick();
        chk("rand_drain", 32'(exp_q.size()), 32'd0);

        // T5: clr_req ignored while a response is stalled
        rsp_rdy = 1'b0;
        issue(1'b0, 9'h005, 7'h00, 7'h00);
        clr_req = 1'b1;
        #1;
        chk("t5_clr_rdy", 32'(req_rdy), 32'd0);
        @(posedge CLK);
        #1;
        clr_req = 1'b0;
        #1;
        chk("t5_ignored", {29'd0, init_done, rsp_vld, sram_cen}, {29'd0, 3'b111});
        rsp_rdy = 1'b1;
        tick();
        chk("t5_pop", 32'(exp_q.size()), 32'd0);

        // T5: clr_req in IDLE restarts the full sweep
        clr_req = 1'b1;
        #1;
        chk("t5_clr_rdy_idle", 32'(req_rdy), 32'd0);
        @(posedge CLK);
        #1;
        clr_req = 1'b0;
        sweep(0, DEPTH);
        #1;
        chk("t5_done", 32'(init_done), 32'd1);
        fill_shadow_init();
        for (int r = 0; r < 16; r++) begin
            issue(1'b0, AW'($urandom_range(0, 15)), 7'h00, 7'h00);
            chk("t5_init_val", 32'(rsp_data), 32'(INIT_VAL));
        end
        tick();

        // T6: reset mid-sweep at cnt=200
        issue(1'b1, 9'h1FF, 7'h41, 7'h7F);
        issue(1'b1, 9'h0C8, 7'h19, 7'h7F);
        do_reset();
        sweep(0, 200);
        RST = 1'b1;
        #1;
        chk("t6_rst_cen", {30'd0, sram_cen, req_rdy}, 32'b10);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sweep(0, DEPTH);
        fill_shadow_init();
        for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), 7'h00, 7'h00);
        tick();
        tick();
        chk("t6_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
